// File: rtl/umi_pkt_fifo_if.sv
// UMI packet valid/ready channel shared by both sides of umi_pkt_fifo.
// master drives valid/packet and samples ready; slave does the reverse.
interface umi_pkt_fifo_if #(
    parameter int unsigned PW = 256
);
    logic          valid;
    logic [PW-1:0] packet;
    logic          ready;

    modport master (
        output valid,
        output packet,
        input  ready
    );

    modport slave (
        input  valid,
        input  packet,
        output ready
    );
endinterface

// File: rtl/umi_pkt_fifo.sv
// Elastic first-word-fall-through packet buffer for the umi_mem rx path.
// Holds up to DEPTH packets; in_umi.ready is independent of out_umi.ready.
module umi_pkt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = 256,
    parameter int unsigned AFULL = DEPTH - 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   nreset,
    umi_pkt_fifo_if.slave          in_umi,
    umi_pkt_fifo_if.master         out_umi,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PTRW = AW + 1;

    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            push;
    logic            pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Extra pointer MSB distinguishes a full wrap from an empty buffer.
    assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign almost_full = (count >= CW'(AFULL));

    // Ready is gated only by registered fullness and reset, so a pop in the
    // same cycle never opens a slot for a push.
    assign in_umi.ready = nreset & ~full;

    assign out_umi.valid  = ~empty;
    assign out_umi.packet = mem[rd_idx];

    assign push = in_umi.valid & in_umi.ready;
    assign pop  = out_umi.valid & out_umi.ready;

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= in_umi.packet;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
